// File: rtl/window_fetch_queue_pkg.sv
// Shared definitions for the sliding-window fetch queue: state encoding,
// a constant clog2 helper and the default window slot width.
package window_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH     = 1;
    // One window slot holds one memory word: CH samples of DATA_W bits.
    localparam int SLOT_W     = DEF_CH * DEF_DATA_W;

    // Ceiling log2 for sizing counters; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/window_fetch_queue_if.sv
// Block RAM read port bundle: the queue is the master issuing reads,
// the RAM is the slave returning data RD_LAT cycles later.
interface window_fetch_queue_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_en, output mem_addr, input  mem_data);
    modport slave  (input  mem_en, input  mem_addr, output mem_data);
endinterface

// File: rtl/window_fetch_queue_rd_lat_pipe.sv
// Valid delay line matching the RAM read latency; marks the cycle in
// which a previously issued read's data is present on mem_data.
module window_fetch_queue_rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    output logic out_valid
);

    logic [RD_LAT-1:0] pipe_r;

    // Shift issue markers toward the output; clear drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_r <= '0;
        end else if (clear) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= in_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign out_valid = pipe_r[RD_LAT-1];

endmodule

// File: rtl/window_fetch_queue.sv
// Sliding-window fetch queue: streams LEN sequential words from a block RAM
// starting at BASE_ADDR into a DEPTH-entry window (slot 0 oldest).
module window_fetch_queue
    import window_fetch_queue_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CH        = 1,
    parameter int DEPTH     = 5,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int BASE_ADDR = 0,
    parameter int LEN       = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            work,
    input  logic                            clear,
    input  logic                            hold,
    window_fetch_queue_if.master            mem,
    output logic [DEPTH*CH*DATA_W-1:0]      window,
    output logic                            win_valid,
    output logic                            is_full,
    output logic [clog2(DEPTH+1)-1:0]       count,
    output logic                            done
);

    localparam int W_SLOT = CH * DATA_W;
    localparam int CNT_W  = clog2(LEN + 1);
    localparam int CW     = clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  LEN_C   = CNT_W'(LEN);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t                         state_r;
    state_t                         state_s;
    logic [CNT_W-1:0]               issued_r;
    logic [CNT_W-1:0]               received_r;
    logic [DEPTH-1:0][W_SLOT-1:0]   win_r;
    logic [CW-1:0]                  count_r;
    logic [CW-1:0]                  count_s;
    logic                           mem_en_r;
    logic [ADDR_W-1:0]              mem_addr_r;
    logic                           win_valid_r;
    logic                           is_full_r;
    logic                           done_r;
    logic                           issue_s;
    logic                           done_s;
    logic                           land_s;

    window_fetch_queue_rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (mem_en_r),
        .out_valid (land_s)
    );

    // State register; clear restarts from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: start on work, stop issuing at LEN, finish when all words landed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (work && !hold) state_s = ST_FETCH;
                else               state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (issued_r == LEN_C) state_s = ST_DRAIN;
                else                   state_s = ST_FETCH;
            end
            ST_DRAIN: begin
                if (received_r == LEN_C) state_s = ST_DONE;
                else                     state_s = ST_DRAIN;
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: read issue qualifier, completion flag and saturating count.
    always_comb begin
        issue_s = 1'b0;
        done_s  = 1'b0;
        count_s = count_r;
        issue_s = ((state_r == ST_IDLE) || (state_r == ST_FETCH)) &&
                  work && !hold && (issued_r < LEN_C);
        done_s  = (state_s == ST_DONE);
        if (count_r == DEPTH_C) begin
            count_s = count_r;
        end else begin
            count_s = count_r + CW'(1);
        end
    end

    // Read issue: one sequential address per cycle; address holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= BASE_C;
            issued_r   <= '0;
        end else if (clear) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= BASE_C;
            issued_r   <= '0;
        end else if (issue_s) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= BASE_C + ADDR_W'(issued_r);
            issued_r   <= issued_r + CNT_W'(1);
        end else begin
            mem_en_r   <= 1'b0;
        end
    end

    // Return path: shift landed word into the newest slot, track fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r       <= '0;
            count_r     <= '0;
            received_r  <= '0;
            win_valid_r <= 1'b0;
            is_full_r   <= 1'b0;
        end else if (clear) begin
            win_r       <= '0;
            count_r     <= '0;
            received_r  <= '0;
            win_valid_r <= 1'b0;
            is_full_r   <= 1'b0;
        end else if (land_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                win_r[i] <= win_r[i+1];
            end
            win_r[DEPTH-1] <= mem.mem_data;
            count_r        <= count_s;
            received_r     <= received_r + CNT_W'(1);
            win_valid_r    <= (count_s == DEPTH_C);
            is_full_r      <= (count_s == DEPTH_C);
        end else begin
            win_valid_r    <= 1'b0;
        end
    end

    // Completion flag follows entry into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else if (clear) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_s;
        end
    end

    assign mem.mem_en   = mem_en_r;
    assign mem.mem_addr = mem_addr_r;
    assign window       = win_r;
    assign win_valid    = win_valid_r;
    assign is_full      = is_full_r;
    assign count        = count_r;
    assign done         = done_r;

endmodule

// File: tb/tb_window_fetch_queue.sv
// Randomized bench for window_fetch_queue: three configurations share one
// control stream and are checked against a transaction-level model.
module tb_window_fetch_queue;

    logic clk = 1'b0;
    logic rst;
    logic work;
    logic clear;
    logic hold;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // configuration per instance: 0 = basic, 1 = RD_LAT 3 / LEN 6, 2 = CH 3
    int lat_p [3] = '{1, 3, 1};
    int len_p [3] = '{8, 6, 8};
    int ch_p  [3] = '{1, 1, 3};

    window_fetch_queue_if #(.ADDR_W(10), .WORD_W(8))  mif0 ();
    window_fetch_queue_if #(.ADDR_W(10), .WORD_W(8))  mif1 ();
    window_fetch_queue_if #(.ADDR_W(10), .WORD_W(24)) mif2 ();

    logic [39:0]  win0, win1;
    logic [119:0] win2;
    logic         wv0, wv1, wv2, full0, full1, full2, done0, done1, done2;
    logic [2:0]   cnt0, cnt1, cnt2;

    window_fetch_queue #(.DATA_W(8), .CH(1), .DEPTH(5), .ADDR_W(10), .RD_LAT(1),
                         .BASE_ADDR(0), .LEN(8)) dut0 (
        .clk(clk), .rst(rst), .work(work), .clear(clear), .hold(hold), .mem(mif0),
        .window(win0), .win_valid(wv0), .is_full(full0), .count(cnt0), .done(done0));

    window_fetch_queue #(.DATA_W(8), .CH(1), .DEPTH(5), .ADDR_W(10), .RD_LAT(3),
                         .BASE_ADDR(0), .LEN(6)) dut1 (
        .clk(clk), .rst(rst), .work(work), .clear(clear), .hold(hold), .mem(mif1),
        .window(win1), .win_valid(wv1), .is_full(full1), .count(cnt1), .done(done1));

    window_fetch_queue #(.DATA_W(8), .CH(3), .DEPTH(5), .ADDR_W(10), .RD_LAT(1),
                         .BASE_ADDR(0), .LEN(8)) dut2 (
        .clk(clk), .rst(rst), .work(work), .clear(clear), .hold(hold), .mem(mif2),
        .window(win2), .win_valid(wv2), .is_full(full2), .count(cnt2), .done(done2));

    // Memory contents: CH=1 -> addr[7:0]; CH=3 -> {addr, addr+1, addr+2}.
    function automatic logic [23:0] mem_word(input int k, input int a);
        logic [7:0] b0, b1, b2;
        b0 = 8'(a);
        b1 = 8'(a + 1);
        b2 = 8'(a + 2);
        if (ch_p[k] == 3) return {b0, b1, b2};
        else              return {16'd0, b0};
    endfunction

    // RAM models: data appears RD_LAT cycles after the enable; garbage otherwise.
    logic [7:0]  m0_q;
    logic [7:0]  m1_q [3];
    logic [23:0] m2_q;

    always @(posedge clk) begin
        m0_q    <= mif0.mem_en ? 8'(mem_word(0, int'(mif0.mem_addr))) : 8'($urandom);
        m1_q[0] <= mif1.mem_en ? 8'(mem_word(1, int'(mif1.mem_addr))) : 8'($urandom);
        m1_q[1] <= m1_q[0];
        m1_q[2] <= m1_q[1];
        m2_q    <= mif2.mem_en ? mem_word(2, int'(mif2.mem_addr)) : 24'($urandom);
    end

    assign mif0.mem_data = m0_q;
    assign mif1.mem_data = m1_q[2];
    assign mif2.mem_data = m2_q;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 fetching, 2 draining, 3 done
    int  ecnt;
    int  phase [3];
    int  issued [3];
    int  received [3];
    int  clear_edge [3];
    bit  exp_en [3];
    int  exp_addr [3];
    bit  exp_wv [3];
    bit  iss_hist [3][0:4095];

    task automatic model_reset(input int k);
        phase[k]      = 0;
        issued[k]     = 0;
        received[k]   = 0;
        exp_en[k]     = 1'b0;
        exp_addr[k]   = 0;
        exp_wv[k]     = 1'b0;
        clear_edge[k] = ecnt;
    endtask

    // One clock edge of the model, using the inputs held before the edge.
    task automatic model_step(input int k);
        int nph;
        int src;
        iss_hist[k][ecnt] = 1'b0;
        if (clear) begin
            model_reset(k);
        end else begin
            nph = phase[k];
            if (phase[k] == 0 && work && !hold)              nph = 1;
            if (phase[k] == 1 && issued[k] == len_p[k])      nph = 2;
            if (phase[k] == 2 && received[k] == len_p[k])    nph = 3;
            // a read issued at edge src is sampled RD_LAT+1 edges later
            src = ecnt - 1 - lat_p[k];
            exp_wv[k] = 1'b0;
            if (src > clear_edge[k] && iss_hist[k][src]) begin
                received[k] = received[k] + 1;
                exp_wv[k]   = (received[k] >= 5);
            end
            if ((phase[k] == 0 || phase[k] == 1) && work && !hold && issued[k] < len_p[k]) begin
                exp_en[k]         = 1'b1;
                exp_addr[k]       = issued[k];
                issued[k]         = issued[k] + 1;
                iss_hist[k][ecnt] = 1'b1;
            end else begin
                exp_en[k] = 1'b0;
            end
            phase[k] = nph;
        end
    endtask

    // Window holds the last five words received (words arrive in address order).
    function automatic logic [119:0] exp_window(input int k);
        logic [119:0] w;
        int n;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            n = received[k] - 5 + i;
            if (n >= 0) w = w | (120'(mem_word(k, n)) << (i * 8 * ch_p[k]));
        end
        return w;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic         en, wv, full, dn;
        logic [9:0]   ad;
        logic [2:0]   cnt;
        logic [119:0] win;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin en = mif0.mem_en; ad = mif0.mem_addr; wv = wv0; full = full0;
                         dn = done0; cnt = cnt0; win = 120'(win0); end
                1: begin en = mif1.mem_en; ad = mif1.mem_addr; wv = wv1; full = full1;
                         dn = done1; cnt = cnt1; win = 120'(win1); end
                default: begin en = mif2.mem_en; ad = mif2.mem_addr; wv = wv2; full = full2;
                         dn = done2; cnt = cnt2; win = win2; end
            endcase
            check_val($sformatf("d%0d.mem_en", k),    128'(en),   128'(exp_en[k]));
            check_val($sformatf("d%0d.mem_addr", k),  128'(ad),   128'(exp_addr[k]));
            check_val($sformatf("d%0d.win_valid", k), 128'(wv),   128'(exp_wv[k]));
            check_val($sformatf("d%0d.is_full", k),   128'(full), 128'(received[k] >= 5));
            check_val($sformatf("d%0d.count", k),     128'(cnt),
                      128'((received[k] >= 5) ? 5 : received[k]));
            check_val($sformatf("d%0d.done", k),      128'(dn),   128'(phase[k] == 3));
            check_val($sformatf("d%0d.window", k),    128'(win),  128'(exp_window(k)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        ecnt++;
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        compare_all();
    endtask

    // Asynchronous reset in the middle of a cycle while work is high.
    task automatic async_reset();
        @(negedge clk);
        work = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        work  = 1'b0;
        hold  = 1'b0;
        clear = 1'b0;
        ecnt  = 0;
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // uninterrupted run to completion
        work = 1'b1;
        for (int c = 0; c < 20; c++) step();

        // restart, then stall issue for three cycles shortly after start
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int c = 0; c < 25; c++) begin
            hold = (c >= 3 && c < 6);
            step();
        end
        hold = 1'b0;

        // restart and flush in the middle of fetching
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int c = 0; c < 5; c++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int c = 0; c < 20; c++) step();

        async_reset();

        for (int c = 0; c < 900; c++) begin
            work  = ($urandom_range(0, 7) != 0);
            hold  = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 24) == 0);
            step();
            if (c == 450) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_fetch_queue.md
Name: window_fetch_queue

Overview:
- Parametrised sliding-window fetch queue, next generation of the single-channel image queue.
- Autonomously issues sequential reads to a block RAM read port starting at BASE_ADDR and shifts returned words into a DEPTH-entry window.
- Supports multi-channel words, configurable RAM read latency, bounded transfer length, pause/hold, synchronous flush and a completion flag.
- Feeds convolution window logic downstream of the image BRAM.

Parameters:
- DATA_W, 8, bits per channel sample
- CH, 1, channels packed per memory word (word width = CH*DATA_W)
- DEPTH, 5, window entries
- ADDR_W, 10, memory address width
- RD_LAT, 1, RAM read latency in cycles (>=1)
- BASE_ADDR, 0, first address fetched
- LEN, 1024, words fetched per run (1..2^ADDR_W-BASE_ADDR)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- work  in  1  run enable; starts from IDLE, pauses issue when low
- clear  in  1  synchronous flush/restart
- hold  in  1  stall: suppresses new read issue
- mem_en  out  1  RAM read enable (registered)
- mem_addr  out  ADDR_W  RAM read address (registered)
- mem_data  in  CH*DATA_W  RAM read data
- window  out  DEPTH*CH*DATA_W  slot i at bits [(i+1)*CH*DATA_W-1 -: CH*DATA_W]; slot 0 oldest, slot DEPTH-1 newest
- win_valid  out  1  one-cycle pulse: window updated and complete
- is_full  out  1  DEPTH words held
- count  out  clog2(DEPTH+1)  words held, saturating at DEPTH
- done  out  1  all LEN words received

Behaviour:
- Reset: rst is asynchronous. All outputs, window, counters and the valid pipeline go to 0; mem_addr goes to BASE_ADDR; state goes to IDLE.
- States:
  - IDLE -> FETCH on edge with work=1, hold=0.
  - FETCH -> DRAIN when issued==LEN.
  - DRAIN -> DONE when received==LEN.
  - DONE holds until clear or rst.
- Issue rule:
  - issue = (state==IDLE or FETCH) & work & ~hold & issued<LEN.
  - When issue is true, the next edge sets mem_en=1 and mem_addr=BASE_ADDR+issued, and increments issued.
  - Otherwise mem_en=0 and mem_addr holds its value.
  - One read per cycle maximum, with no gaps when unstalled.
- Return path:
  - A RD_LAT-deep shift pipeline of mem_en marks returning data.
  - A word presented with mem_en in cycle t is sampled from mem_data at the end of cycle t+RD_LAT.
  - On sample: slots shift down (slot i <= slot i+1), slot DEPTH-1 <= mem_data, count <= min(count+1, DEPTH), received++.
- win_valid=1 for the cycle after a sample that leaves count==DEPTH; 0 otherwise.
- is_full = (count==DEPTH).
- done=1 in DONE.
- hold and work=0 block only issue. In-flight reads (up to RD_LAT) still land and shift, so there is no loss or duplication. Resume continues at the next unissued address.
- hold has no effect in DRAIN/DONE.
- clear (synchronous, priority over everything except rst):
  - count, issued, received and the valid pipeline go to 0; in-flight returns are discarded.
  - mem_en=0, mem_addr=BASE_ADDR, done=0, state=IDLE.
  - window contents zeroed.
- Simultaneous clear and work: clear wins; the new run starts on a later edge.
- Counter widths: issued/received use clog2(LEN+1) bits; no wrap permitted.
- LEN<DEPTH: win_valid never asserts; done still asserts.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, DRAIN, DONE)
  - a clog2 helper function
  - a window slot-width localparam CH*DATA_W
- One natural sub-module, rd_lat_pipe: a RD_LAT-stage valid delay line with synchronous clear and asynchronous reset.

Test Plan:
Common setup: DEPTH=5, CH=1, DATA_W=8, RD_LAT=1, BASE_ADDR=0, LEN=8; memory model returns data = addr[7:0].
- Reset: assert rst mid-cycle with work=1 -> mem_en, win_valid, count, done and window all 0 immediately; mem_addr=0.
- Basic run: work=1 from cycle 0 -> mem_en high for exactly 8 consecutive cycles with addr 0..7. First win_valid after word 4 lands, with window slots {0,1,2,3,4} and is_full=1. Then 3 more pulses with windows {1..5}, {2..6}, {3..7}. done=1 one cycle after the last sample.
- Hold: assert hold for 3 cycles right after addr 2 issues -> no mem_en during hold, word 2 still lands. Resume issues addr 3, and the final window sequence is identical to the basic run.
- Clear: clear in the cycle after addr 3 issues -> word 3 is discarded, count=0, state=IDLE. Rerun yields addr 0..7 and the same windows.
- Latency: RD_LAT=3, LEN=6 -> returns lag issue by 3 cycles. Windows are {0..4} and {1..5} only; done after the 6th sample.
- Channels: CH=3, memory word {addr,addr+1,addr+2} -> each slot carries the 24-bit word intact in the required slot order.
